bank_writer: RTL
================

BANK_WRITER -- requirements
Module: bank_writer

Interface
REQ-001 Parameter FRAME_BYTES, default 60000, meaning the number of packed bytes per frame (800x600 pixels at 1 bpp).
REQ-002 Parameter ADDR_W, default 16, meaning the bank address width; FRAME_BYTES SHALL be no greater than 2**ADDR_W.
REQ-003 Port CLK_40, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port write_bank1, input, 1 bit: level, requests frame fill into bank 1.
REQ-006 Port write_bank2, input, 1 bit: level, requests frame fill into bank 2.
REQ-007 Port switch_mode, input, 1 bit: one-cycle pulse marking the bank-swap frame boundary.
REQ-008 Port s_data, input, 8 bits: stream payload.
REQ-009 Ports s_valid (input, 1 bit) and s_ready (output, 1 bit): stream handshake; a beat transfers when both are high.
REQ-010 Ports bank1_we and bank2_we, outputs, 1 bit each: write strobes, at most one high per cycle.
REQ-011 Port wr_addr, output, ADDR_W bits: byte address of the current write.
REQ-012 Port wr_data, output, 8 bits: packed pixels, MSB = leftmost pixel.
REQ-013 Ports frame_done and underrun, outputs, 1 bit each: one-cycle status pulses.

Function
REQ-014 FSM states: IDLE, FILL, DONE.
- IDLE->FILL when write_bank1|write_bank2.
- FILL->DONE on the write with wr_addr==FRAME_BYTES-1.
- DONE->FILL on switch_mode with a write request high.
- FILL/DONE->IDLE when both requests are low.
REQ-015 On IDLE->FILL or DONE->FILL, the block SHALL latch the target bank: bank 1 if write_bank1, else bank 2; if both are high, bank 1 wins.
REQ-016 s_ready = state==FILL and (RLE mode) run counter idle; s_ready SHALL NOT depend combinationally on s_valid.
REQ-017 Raw mode: a byte accepted in cycle N SHALL appear on wr_data/wr_addr with the latched bank's we high in cycle N+1 (registered, 1-cycle latency).
REQ-018 wr_addr SHALL start at 0 on every entry to FILL and increment by 1 per write, never exceeding FRAME_BYTES-1.
REQ-019 frame_done SHALL pulse high in the same cycle as the final write of a frame.
REQ-020 switch_mode during FILL, before the frame completes, SHALL pulse underrun for 1 cycle, discard partial state, re-latch the bank and restart at address 0 in FILL.
REQ-021 A drop of the latched bank's request during FILL SHALL abort to IDLE with no further writes; the in-flight registered write SHALL still complete.
REQ-022 Bytes SHALL NOT be accepted in IDLE or DONE (s_ready=0).

Reset
REQ-023 While reset_n is low: state=IDLE; s_ready, bank1_we, bank2_we, frame_done and underrun = 0; wr_addr and wr_data = 0; run counter and pixel shift register cleared. Reset mid-frame SHALL discard all partial data.
REQ-024 After release, the first state change SHALL occur on the first CLK_40 edge with reset_n high.

Configuration
REQ-025 Macro BANK_WRITER_RLE_EN.
- Defined: each s_data byte is an RLE token with bit7 = pixel value and bits6:0 = run length minus 1 (1..128 pixels).
- Defined: pixels expand one per cycle into a shift register, and a byte is written when 8 pixels accumulate.
- Defined: s_ready is low while a run is expanding.
- Defined: a run crossing the frame end SHALL be truncated, and excess pixels discarded.
- Undefined: raw packed-byte mode (REQ-017) with no expansion logic.

Verification (FRAME_BYTES=4 unless stated)
REQ-026 Raw mode, write_bank2=1, bytes 0xA1,0xB2,0xC3,0xD4 sent back-to-back -> bank2_we on 4 consecutive cycles, addresses 0..3 carrying those bytes, frame_done with address 3, then s_ready=0.
REQ-027 In DONE, switch_mode pulse with write_bank1=1 -> next frame written to bank1_we starting at address 0.
REQ-028 switch_mode after 2 of 4 bytes -> underrun pulse, next accepted byte written at address 0.
REQ-029 reset_n low for 1 cycle mid-frame -> all outputs 0 immediately (asynchronous), IDLE; the refill starts at address 0.
REQ-030 RLE_EN, tokens 0x84 (5 ones) and 0x02 (3 zeros) -> one write of 0xF8 at address 0, 8 cycles after the first accept.
REQ-031 RLE_EN, FRAME_BYTES=1, token 0xFF (128 ones) -> a single write of 0xFF, frame_done, remaining 120 pixels discarded, no further writes.

Source files
------------

// File: rtl/bank_writer.sv
// bank_writer: fills one of two frame banks from a byte stream, one packed byte per write.
// Build option BANK_WRITER_RLE_EN: stream bytes are run-length tokens expanded to 1 bpp pixels.
module bank_writer #(
  parameter int FRAME_BYTES = 60000,
  parameter int ADDR_W      = 16
) (
  input  logic              CLK_40,
  input  logic              reset_n,
  input  logic              write_bank1,
  input  logic              write_bank2,
  input  logic              switch_mode,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              bank1_we,
  output logic              bank2_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              underrun
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e            state_q;
  logic              bank2_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              s_ready_q, bank1_we_q, bank2_we_q, frame_done_q, underrun_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  logic       any_req, lat_req, accept, wr_fire, last_wr, run_busy_d;
  logic [7:0] wr_byte;

  assign any_req = write_bank1 | write_bank2;
  assign lat_req = bank2_q ? write_bank2 : write_bank1;
  assign accept  = s_valid & s_ready_q;
  assign last_wr = wr_fire && (cnt_q == LAST);

`ifdef BANK_WRITER_RLE_EN
  logic [6:0] rem_q, rem_d;
  logic       pix_q, pix_d, step, fill_adv;
  logic [7:0] sh_q;
  logic [2:0] bits_q;

  // The accepting cycle already shifts the token's first pixel, so a
  // one-pixel token never stalls the stream.
  always_comb begin
    step  = accept | (rem_q != 7'd0);
    pix_d = accept ? s_data[7] : pix_q;
    rem_d = rem_q;
    if (accept)                rem_d = s_data[6:0];
    else if (rem_q != 7'd0)    rem_d = rem_q - 7'd1;
    wr_byte    = {sh_q[6:0], pix_d};
    wr_fire    = step && (bits_q == 3'd7);
    run_busy_d = (rem_d != 7'd0);
  end

  assign fill_adv = (state_q == FILL) && lat_req && !switch_mode;

  // Any exit from normal filling (abort, restart, frame end) drops the run.
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      pix_q  <= 1'b0;
      sh_q   <= '0;
      bits_q <= '0;
    end else if (fill_adv && !last_wr) begin
      rem_q <= rem_d;
      pix_q <= pix_d;
      if (step) begin
        sh_q   <= wr_byte;
        bits_q <= bits_q + 3'd1;
      end
    end else begin
      rem_q  <= '0;
      pix_q  <= 1'b0;
      sh_q   <= '0;
      bits_q <= '0;
    end
  end
`else
  assign wr_fire    = accept;
  assign wr_byte    = s_data;
  assign run_busy_d = 1'b0;
`endif

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bank2_q      <= 1'b0;
      cnt_q        <= '0;
      s_ready_q    <= 1'b0;
      bank1_we_q   <= 1'b0;
      bank2_we_q   <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      bank1_we_q   <= 1'b0;
      bank2_we_q   <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q   <= FILL;
            bank2_q   <= !write_bank1;
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
          end
        end
        FILL: begin
          if (!lat_req) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
          end else if (switch_mode) begin
            underrun_q <= 1'b1;
            bank2_q    <= !write_bank1;
            cnt_q      <= '0;
            s_ready_q  <= 1'b1;
          end else begin
            if (wr_fire) begin
              wr_addr_q  <= cnt_q;
              wr_data_q  <= wr_byte;
              bank1_we_q <= !bank2_q;
              bank2_we_q <= bank2_q;
              cnt_q      <= cnt_q + ADDR_W'(1);
            end
            if (last_wr) begin
              state_q      <= DONE;
              frame_done_q <= 1'b1;
              s_ready_q    <= 1'b0;
            end else begin
              s_ready_q <= !run_busy_d;
            end
          end
        end
        DONE: begin
          if (!any_req) begin
            state_q <= IDLE;
          end else if (switch_mode) begin
            state_q   <= FILL;
            bank2_q   <= !write_bank1;
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign bank1_we   = bank1_we_q;
  assign bank2_we   = bank2_we_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
endmodule
